// File: rtl/trackball_counter_bank.sv
// Bank of trackball/spinner step counters: each axis has its clock/direction lines synchronised and
// deglitched, keeps a signed step count, and is readable as a status byte.
module trackball_counter_bank #(
  parameter int NUM_AXES    = 4,
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int SATURATE    = 0,
  parameter int CLR_ON_READ = 0
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [NUM_AXES-1:0]                                   axis_dir,
  input  logic [NUM_AXES-1:0]                                   axis_clk,
  input  logic                                                  enable,
  input  logic                                                  clr,
  input  logic                                                  rd_en,
  input  logic [((NUM_AXES > 1) ? $clog2(NUM_AXES) : 1)-1:0]    rd_sel,
  output logic [7:0]                                            rd_data,
  output logic                                                  rd_valid,
  output logic [NUM_AXES*CNT_W-1:0]                             count_flat
);

  localparam int SEL_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] dir_sync [NUM_AXES];
  logic [SYNC_STAGES-1:0] clk_sync [NUM_AXES];
  logic [3:0]             run      [NUM_AXES];
  logic [CNT_W-1:0]       count     [NUM_AXES];
  logic [CNT_W-1:0]       count_nxt [NUM_AXES];
  logic [NUM_AXES-1:0]    filt, filt_q, step, dir_now, clear_hit;
  logic [NUM_AXES-1:0]    ovf, ovf_nxt, last_dir, last_dir_nxt;
  logic [7:0]             rd_byte;

  always_comb begin
    step      = '0;
    dir_now   = '0;
    clear_hit = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      step[i]      = filt[i] & ~filt_q[i] & enable;
      dir_now[i]   = dir_sync[i][SYNC_STAGES-1];
      clear_hit[i] = clr | ((CLR_ON_READ != 0) & rd_en & (rd_sel == SEL_W'(i)));
    end
  end

  // The filter only moves after FILTER_LEN consecutive disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt   <= '0;
      filt_q <= '0;
      for (int i = 0; i < NUM_AXES; i++) begin
        dir_sync[i] <= '0;
        clk_sync[i] <= '0;
        run[i]      <= '0;
      end
    end else begin
      filt_q <= filt;
      for (int i = 0; i < NUM_AXES; i++) begin
        dir_sync[i] <= {dir_sync[i][SYNC_STAGES-2:0], axis_dir[i]};
        clk_sync[i] <= {clk_sync[i][SYNC_STAGES-2:0], axis_clk[i]};
        if (clk_sync[i][SYNC_STAGES-1] == filt[i]) begin
          run[i] <= '0;
        end else if (run[i] == 4'(FILTER_LEN - 1)) begin
          filt[i] <= clk_sync[i][SYNC_STAGES-1];
          run[i]  <= '0;
        end else begin
          run[i] <= run[i] + 4'd1;
        end
      end
    end
  end

  // A clear in the same cycle as a step starts the step from zero and leaves the overflow flag clear.
  always_comb begin
    ovf_nxt      = '0;
    last_dir_nxt = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      count_nxt[i]    = clear_hit[i] ? '0 : count[i];
      ovf_nxt[i]      = clear_hit[i] ? 1'b0 : ovf[i];
      last_dir_nxt[i] = last_dir[i];
      if (step[i]) begin
        last_dir_nxt[i] = dir_now[i];
        if (dir_now[i] && (count_nxt[i] == CNT_MAX)) begin
          ovf_nxt[i] = ovf_nxt[i] | ~clear_hit[i];
          if (SATURATE == 0) count_nxt[i] = '0;
        end else if (!dir_now[i] && (count_nxt[i] == '0)) begin
          ovf_nxt[i] = ovf_nxt[i] | ~clear_hit[i];
          if (SATURATE == 0) count_nxt[i] = CNT_MAX;
        end else if (dir_now[i]) begin
          count_nxt[i] = count_nxt[i] + CNT_W'(1);
        end else begin
          count_nxt[i] = count_nxt[i] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < NUM_AXES; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_byte[7]         = last_dir[i];
        rd_byte[6]         = ovf[i];
        rd_byte[CNT_W-1:0] = count[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf      <= '0;
      last_dir <= '0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      for (int i = 0; i < NUM_AXES; i++) count[i] <= '0;
    end else begin
      ovf      <= ovf_nxt;
      last_dir <= last_dir_nxt;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_byte;
      for (int i = 0; i < NUM_AXES; i++) count[i] <= count_nxt[i];
    end
  end

  always_comb begin
    count_flat = '0;
    for (int i = 0; i < NUM_AXES; i++) count_flat[i*CNT_W +: CNT_W] = count[i];
  end

endmodule

// File: tb/tb_trackball_counter_bank.sv
// Drives three differently configured counter banks with the same random pulse trains and compares
// them against an event-level model: steps land a fixed latency after a qualifying pulse starts.
module tb_trackball_counter_bank;

  localparam int S = 2;
  localparam int F = 3;
  localparam int NAX [3] = '{4, 3, 4};
  localparam int CW  [3] = '{4, 3, 4};
  localparam int SAT [3] = '{0, 1, 0};
  localparam int COR [3] = '{0, 0, 1};

  logic        clk = 1'b0;
  logic        reset, enable, clr, rd_en;
  logic [1:0]  rd_sel;
  logic [3:0]  axis_dir, axis_clk;
  logic [7:0]  rd_data0, rd_data1, rd_data2;
  logic        rd_valid0, rd_valid1, rd_valid2;
  logic [15:0] cf0, cf2;
  logic [8:0]  cf1;

  always #5 clk = ~clk;

  trackball_counter_bank #(.NUM_AXES(4), .CNT_W(4), .SYNC_STAGES(S), .FILTER_LEN(F),
                           .SATURATE(0), .CLR_ON_READ(0)) dut0 (
    .clk(clk), .reset(reset), .axis_dir(axis_dir), .axis_clk(axis_clk), .enable(enable),
    .clr(clr), .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .count_flat(cf0));

  trackball_counter_bank #(.NUM_AXES(3), .CNT_W(3), .SYNC_STAGES(S), .FILTER_LEN(F),
                           .SATURATE(1), .CLR_ON_READ(0)) dut1 (
    .clk(clk), .reset(reset), .axis_dir(axis_dir[2:0]), .axis_clk(axis_clk[2:0]), .enable(enable),
    .clr(clr), .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .count_flat(cf1));

  trackball_counter_bank #(.NUM_AXES(4), .CNT_W(4), .SYNC_STAGES(S), .FILTER_LEN(F),
                           .SATURATE(0), .CLR_ON_READ(1)) dut2 (
    .clk(clk), .reset(reset), .axis_dir(axis_dir), .axis_clk(axis_clk), .enable(enable),
    .clr(clr), .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .count_flat(cf2));

  int n_total = 0;
  int n_bad   = 0;
  bit chk_on  = 1'b0;
  int cyc     = 0;
  int t0      = -100;
  int pulses_left = 5;

  int m_cnt [3][4];
  int m_ovf [3][4];
  int m_dir [3][4];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];

  int pend_t [$];
  int pend_a [$];
  bit pend_d [$];
  int phase_left [4];
  bit level      [4];
  bit was_real   [4];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void pushExp(input int d, input logic [7:0] v);
    case (d)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic logic [15:0] expFlat(input int d);
    logic [15:0] v = 16'h0;
    for (int a = 0; a < NAX[d]; a++) v = v | (16'(m_cnt[d][a]) << (a * CW[d]));
    return v;
  endfunction

  // Reference behaviour for one clock edge, using the inputs that were presented to that edge.
  function automatic void modelEdge(input int e);
    bit st [4] = '{0, 0, 0, 0};
    bit sd [4] = '{0, 0, 0, 0};
    int lim, nv, sel;
    bit hit;
    for (int k = pend_t.size() - 1; k >= 0; k--) begin
      if (pend_t[k] == e) begin
        st[pend_a[k]] = 1'b1;
        sd[pend_a[k]] = pend_d[k];
        pend_t.delete(k);
        pend_a.delete(k);
        pend_d.delete(k);
      end
    end
    sel = int'(rd_sel);
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        for (int a = 0; a < 4; a++) begin
          m_cnt[d][a] = 0;
          m_ovf[d][a] = 0;
          m_dir[d][a] = 0;
        end
        continue;
      end
      if (rd_en)
        pushExp(d, (sel < NAX[d]) ? 8'(m_dir[d][sel] * 128 + m_ovf[d][sel] * 64 + m_cnt[d][sel]) : 8'h00);
      for (int a = 0; a < NAX[d]; a++) begin
        hit = clr || (COR[d] != 0 && rd_en && sel == a);
        if (hit) begin
          m_cnt[d][a] = 0;
          m_ovf[d][a] = 0;
        end
        if (st[a] && enable) begin
          lim = (1 << CW[d]) - 1;
          nv  = m_cnt[d][a] + (sd[a] ? 1 : -1);
          m_dir[d][a] = int'(sd[a]);
          if (nv < 0 || nv > lim) begin
            if (!hit) m_ovf[d][a] = 1;
            nv = (SAT[d] != 0) ? m_cnt[d][a] : (nv + lim + 1) % (lim + 1);
          end
          m_cnt[d][a] = nv;
        end
      end
    end
  endfunction

  // mode 0: random pulses and glitches; mode 1: five clean 8/8 pulses on axis 1, dir=1; mode 2: let lines go idle.
  task automatic genAxis(input int a, input int mode);
    if (phase_left[a] == 0) begin
      if (level[a]) begin
        level[a] = 1'b0;
        phase_left[a] = (mode == 1) ? 8 :
                        (was_real[a] ? int'($urandom_range(F + 1, F + 4)) : int'($urandom_range(1, 3)));
      end else if (mode == 0 || (mode == 1 && a == 1 && pulses_left > 0)) begin
        level[a]      = 1'b1;
        was_real[a]   = (mode == 1) || ($urandom_range(0, 2) != 0);
        phase_left[a] = (mode == 1) ? 8 :
                        (was_real[a] ? int'($urandom_range(F, F + 3)) : int'($urandom_range(1, F - 1)));
        axis_dir[a]   = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        if (mode == 1) begin
          if (t0 < 0) t0 = cyc + 1;
          pulses_left--;
        end
        if (was_real[a]) begin
          pend_t.push_back(cyc + 1 + S + F);
          pend_a.push_back(a);
          pend_d.push_back(axis_dir[a]);
        end
      end
    end
    axis_clk[a] = level[a];
    if (phase_left[a] > 0) phase_left[a]--;
  endtask

  task automatic applyStimulus(input int mode, input bit rst_v, input bit rd_v, input logic [1:0] sel_v);
    @(posedge clk);
    #2;
    cyc++;
    modelEdge(cyc);
    if (cyc == t0 + S + F - 1) checkOutput("latency_before_step", 16'(cf0[7:4]), 16'd0);
    if (cyc == t0 + S + F)     checkOutput("latency_first_step", 16'(cf0[7:4]), 16'd1);
    for (int a = 0; a < 4; a++) genAxis(a, mode);
    if (mode == 0) begin
      reset  = 1'b0;
      clr    = ($urandom_range(0, 59) == 0);
      rd_en  = ($urandom_range(0, 3) == 0);
      rd_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) enable = ~enable;
    end else begin
      reset  = rst_v;
      clr    = 1'b0;
      rd_en  = rd_v;
      rd_sel = sel_v;
      enable = 1'b1;
    end
  endtask

  // Scoreboard side: pop an expected byte whenever any bank presents rd_valid, and track live counters.
  always @(negedge clk) begin
    if (chk_on) begin
      if (rd_valid0 === 1'b1) begin
        if (q0.size() == 0) checkOutput("rd_valid_spurious_d0", 16'(rd_valid0), 16'd0);
        else checkOutput("rd_data_d0", 16'(rd_data0), 16'(q0.pop_front()));
      end
      if (rd_valid1 === 1'b1) begin
        if (q1.size() == 0) checkOutput("rd_valid_spurious_d1", 16'(rd_valid1), 16'd0);
        else checkOutput("rd_data_d1", 16'(rd_data1), 16'(q1.pop_front()));
      end
      if (rd_valid2 === 1'b1) begin
        if (q2.size() == 0) checkOutput("rd_valid_spurious_d2", 16'(rd_valid2), 16'd0);
        else checkOutput("rd_data_d2", 16'(rd_data2), 16'(q2.pop_front()));
      end
      checkOutput("count_flat_d0", cf0, expFlat(0));
      checkOutput("count_flat_d1", 16'(cf1), expFlat(1));
      checkOutput("count_flat_d2", cf2, expFlat(2));
    end
  end

  initial begin
    reset = 1'b1; clr = 1'b0; rd_en = 1'b0; rd_sel = 2'd0; enable = 1'b1;
    axis_dir = 4'h0; axis_clk = 4'h0;
    for (int a = 0; a < 4; a++) begin
      phase_left[a] = 0;
      level[a]      = 1'b0;
      was_real[a]   = 1'b0;
    end

    applyStimulus(2, 1, 0, 2'd0);
    chk_on = 1'b1;
    repeat (2) applyStimulus(2, 1, 0, 2'd0);
    applyStimulus(2, 0, 1, 2'd0);
    applyStimulus(1, 0, 0, 2'd0);
    checkOutput("reset_read_axis0", 16'(rd_data0), 16'h00);

    repeat (90) applyStimulus(1, 0, 0, 2'd0);
    repeat (10) applyStimulus(2, 0, 0, 2'd0);
    checkOutput("five_steps_d0", 16'(cf0[7:4]), 16'd5);
    checkOutput("five_steps_d1", 16'(cf1[5:3]), 16'd5);
    checkOutput("five_steps_d2", 16'(cf2[7:4]), 16'd5);
    applyStimulus(2, 0, 1, 2'd1);
    applyStimulus(2, 0, 0, 2'd0);
    checkOutput("read_axis1_d0", 16'(rd_data0), 16'h85);
    checkOutput("read_axis1_d2", 16'(rd_data2), 16'h85);
    applyStimulus(2, 0, 1, 2'd1);
    applyStimulus(2, 0, 0, 2'd0);
    checkOutput("reread_after_clear_d2", 16'(rd_data2), 16'h80);
    checkOutput("reread_no_clear_d0", 16'(rd_data0), 16'h85);

    repeat (3000) applyStimulus(0, 0, 0, 2'd0);
    repeat (30) applyStimulus(2, 0, 0, 2'd0);

    applyStimulus(2, 1, 1, 2'd2);
    applyStimulus(2, 0, 0, 2'd0);
    checkOutput("reset_drops_read", 16'({rd_valid0, rd_valid1, rd_valid2}), 16'd0);

    repeat (1500) applyStimulus(0, 0, 0, 2'd0);
    repeat (30) applyStimulus(2, 0, 0, 2'd0);
    checkOutput("scoreboard_drained", 16'(q0.size() + q1.size() + q2.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/trackball_counter_bank.md
# trackball_counter_bank

Parametrised bank of trackball/spinner position counters for the arcade cores. It takes raw direction/clock line pairs from the control panel, synchronises and deglitches them, and keeps a signed-direction step counter per axis. It presents each axis as a CPU-readable byte on the shared data bus path. It generalises the fixed two-axis, single-player trackball reader to N axes, configurable counter width, wrap or saturate mode, clear-on-read, and sticky overflow reporting.

## Interface
Parameters:
- NUM_AXES, 4, number of axes (2 per trackball); range 1..16
- CNT_W, 4, counter width; range 2..6
- SYNC_STAGES, 2, synchroniser flops per input line; range 2..4
- FILTER_LEN, 3, consecutive equal samples required to accept a level change on an axis clock line; range 1..15
- SATURATE, 0, 0 = counters wrap modulo 2^CNT_W; 1 = counters clamp at 0 and 2^CNT_W-1
- CLR_ON_READ, 0, 1 = a read clears the selected axis counter and its overflow flag

Ports:
- clk  in  1  system clock (clk_50 domain)
- reset  in  1  synchronous, active-high reset
- axis_dir  in  NUM_AXES  raw direction lines, asynchronous
- axis_clk  in  NUM_AXES  raw step-clock lines, asynchronous
- enable  in  1  1 = accept steps; 0 = steps are ignored, state is held
- clr  in  1  one-cycle pulse that clears all counters and overflow flags (steerclr)
- rd_en  in  1  one-cycle read strobe
- rd_sel  in  $clog2(NUM_AXES), minimum 1  axis to read
- rd_data  out  8  registered read byte
- rd_valid  out  1  high for one cycle, 1 cycle after rd_en
- count_flat  out  NUM_AXES*CNT_W  live counters for debug/graphics; axis i is at [i*CNT_W +: CNT_W]

## Operation
- Each axis_dir[i] and axis_clk[i] passes through a SYNC_STAGES flop chain. The synchronised clock line feeds a filter:
  - filt[i] takes a new level only after the synchronised value differs from filt[i] for FILTER_LEN consecutive cycles.
  - Any sample equal to filt[i] resets the filter run counter.
- A step occurs on a filtered rising edge (filt[i] 0->1) while enable=1. Falling edges never step.
- Step direction comes from the synchronised dir sampled in the same cycle the rising edge is detected: dir=1 is +1, dir=0 is -1. last_dir[i] holds that direction.
- Wrap mode: count += ±1 modulo 2^CNT_W. ovf[i] sets on every wrap, in either direction.
- Saturate mode: the count is held at a limit. ovf[i] sets when a step is discarded at that limit.
- ovf[i] is sticky until clr, reset, or a clear-on-read.
- rd_data for the selected axis: bit7 = last_dir, bit6 = ovf, bits[CNT_W-1:0] = count, all other bits 0.
- rd_sel >= NUM_AXES reads 8'h00 and clears nothing.
- Simultaneous events on the same axis, same cycle:
  - clr with a step: the count becomes 0 then steps, giving 1 or 2^CNT_W-1. ovf is 0.
  - Clear-on-read with a step: the byte read shows the pre-step value, and the counter ends at 0±1.
  - Counts are never lost.
- enable=0: filter and synchronisers keep running, but detected edges are discarded. Steps are not queued.

## Timing
- Reset values: all counters 0, ovf 0, last_dir 0, filt 0, filter run counters 0, synchronisers 0, rd_data 8'h00, rd_valid 0, count_flat 0.
- Step latency: the count changes on edge SYNC_STAGES + FILTER_LEN + 1, counting the first edge that samples the new raw level as edge 1. With defaults this is edge 6.
- Read: rd_en sampled at edge n. rd_data and rd_valid update at edge n. rd_data holds its value until the next read. rd_valid drops at edge n+1.
- Clear-on-read takes effect at edge n. A back-to-back read at n+1 returns the cleared value.
- Minimum resolvable step period on axis_clk: 2*FILTER_LEN + 2 cycles. Faster input can drop steps but must never corrupt count or direction.
- reset mid-filter or mid-read: all state returns to reset values at that edge. A read in the same cycle as reset is discarded (rd_valid 0).

## Test plan
- Reset, then read axis 0 -> rd_valid pulses once with rd_data=8'h00. count_flat=0.
- Defaults, axis 1 dir=1, 5 clean pulses (8 cycles high, 8 low) -> axis 1 count=5. Read of axis 1 = 8'h85. First count change exactly 6 edges after the first high sample.
- Wrap mode, dir=0, 1 pulse from count 0 -> count=15 and ovf=1, read = 8'h4F. Then clr -> read = 8'h00. SATURATE=1 with the same stimulus -> count=0, read = 8'h40.
- Glitches: axis_clk high for FILTER_LEN-1 cycles, repeated 10 times -> count unchanged. Exactly FILTER_LEN cycles high -> one step.
- CLR_ON_READ=1, axis 2 count=3, read on the same cycle as a +1 step -> read = 8'h83, counter ends at 1. clr coincident with a -1 step -> count=15, ovf=0.
- NUM_AXES=3: rd_sel=3 -> 8'h00 with no side effects. enable=0 during 4 pulses -> no count change, and a pulse after enable returns to 1 is counted.
